// File: rtl/rle_bank_loader_if.sv
// -----------------------------------------------------------------------------
// rle_bank_loader_if
// Bus bundle for rle_bank_loader: the host-side RLE word stream (valid/ready)
// and the round-robin bank write port.
//   in_valid  host -> loader   word valid
//   in_ready  loader -> host   loader can take a word this cycle
//   in_data   host -> loader   RLE word (WORD_W)
//   wr_en     loader -> banks  one-hot bank write strobe (NBANK)
//   wr_addr   loader -> banks  address within the selected bank (ADDR_W)
//   wr_data   loader -> banks  extended element (OUT_W)
// Modports: master = host/bank side, slave = loader.
// -----------------------------------------------------------------------------
interface rle_bank_loader_if #(
  parameter int WORD_W = 32,
  parameter int NBANK  = 4,
  parameter int ADDR_W = 10,
  parameter int OUT_W  = 64
) ();
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic [NBANK-1:0]  wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [OUT_W-1:0]  wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/rle_bank_loader.sv
// -----------------------------------------------------------------------------
// rle_bank_loader
// Expands run-length-encoded host words into a bit buffer, parses a frame of
// {CNT_W-bit count N, N x ELEM_W-bit elements} and writes the elements
// round-robin across NBANK banks (element k -> bank k%NBANK, addr k/NBANK).
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous, active-high reset
//   io_bus    rle_bank_loader_if.slave (in_valid/in_ready/in_data, wr_*)
//   o_busy    frame in progress (element phase)
//   o_done    one-cycle pulse at frame end (incl. N==0 and overflow)
//   o_err     sticky overflow flag, cleared at the next header
//
// Optional build macro
//   RLE_BANK_LOADER_SIGN_EXT_EN  defined: elements sign-extended to OUT_W;
//                                undefined: elements zero-extended.
// -----------------------------------------------------------------------------
module rle_bank_loader #(
  parameter int WORD_W = 32,
  parameter int RUN_W  = 3,
  parameter int CNT_W  = 16,
  parameter int ELEM_W = 16,
  parameter int OUT_W  = 64,
  parameter int NBANK  = 4,
  parameter int ADDR_W = 10,
  parameter int BUF_W  = 128
) (
  input  logic                clk,
  input  logic                rst,
  rle_bank_loader_if.slave    io_bus,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err
);

  localparam int GRP_W  = RUN_W + 1;
  localparam int NGRP   = WORD_W / GRP_W;
  localparam int MAXB   = NGRP * ((1 << RUN_W) - 1);   // most bits one word can add
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int ADD_W  = $clog2(MAXB + 1);
  localparam int K_W    = CNT_W + 1;
  localparam logic [63:0] CAP = 64'(NBANK) << ADDR_W;  // largest legal N

  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  // Valid bits sit left-aligned in r_buf (oldest bit at BUF_W-1); every bit
  // at or below position BUF_W-1-r_fill is kept zero so appends can be OR-ed.
  state_t             r_state;
  logic [FILL_W-1:0]  r_fill;
  logic [BUF_W-1:0]   r_buf;
  logic [K_W-1:0]     r_k;
  logic [CNT_W-1:0]   r_n;
  logic [NBANK-1:0]   r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [OUT_W-1:0]   r_wr_data;
  logic               r_done;
  logic               r_err;

  state_t             w_state_next;
  logic [MAXB-1:0]    w_exp;
  logic [ADD_W-1:0]   w_add;
  logic [BUF_W-1:0]   w_exp_top;
  logic [CNT_W-1:0]   w_hdr;
  logic [ELEM_W-1:0]  w_elem;
  logic [OUT_W-1:0]   w_ext;
  logic [FILL_W-1:0]  w_consume;
  logic [FILL_W-1:0]  w_fill_keep;
  logic [BUF_W-1:0]   w_buf_keep;
  logic [FILL_W-1:0]  w_fill_next;
  logic [BUF_W-1:0]   w_buf_next;
  logic               w_clear;
  logic               w_hdr_take;
  logic               w_hdr_zero;
  logic               w_hdr_ovf;
  logic               w_elem_take;
  logic               w_last;
  logic               w_final;
  logic               w_in_ready;
  logic               w_accept;

  assign w_hdr  = r_buf[BUF_W-1 -: CNT_W];
  assign w_elem = r_buf[BUF_W-1 -: ELEM_W];

`ifdef RLE_BANK_LOADER_SIGN_EXT_EN
  assign w_ext = OUT_W'($signed(w_elem));
`else
  assign w_ext = OUT_W'(w_elem);
`endif

  // RLE expansion: groups MSB-first; each contributes count copies of its bit.
  always_comb begin : p_expand
    logic [GRP_W-1:0] grp;
    // NOTE: every combinational output gets a default before any branch or
    // loop touches it, so no path leaves a value held (no latch inferred).
    w_exp = '0;
    w_add = '0;
    grp   = '0;
    for (int g = 0; g < NGRP; g++) begin
      grp   = io_bus.in_data[WORD_W-1-g*GRP_W -: GRP_W];
      w_exp = (w_exp << grp[RUN_W-1:0])
            | (grp[RUN_W] ? ~({MAXB{1'b1}} << grp[RUN_W-1:0]) : '0);
      w_add = w_add + ADD_W'(grp[RUN_W-1:0]);
    end
  end

  // Left-align the expanded bits so they can be shifted down behind the
  // bits that remain after this cycle's extraction.
  assign w_exp_top = {w_exp, {(BUF_W-MAXB){1'b0}}} << (ADD_W'(MAXB) - w_add);

  // Next-state / extraction decision; uses the fill from before the append.
  always_comb begin
    w_state_next = r_state;
    w_consume    = '0;
    w_clear      = 1'b0;
    w_hdr_take   = 1'b0;
    w_hdr_zero   = 1'b0;
    w_hdr_ovf    = 1'b0;
    w_elem_take  = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      ST_HDR: begin
        if (r_fill >= FILL_W'(CNT_W)) begin
          w_hdr_take = 1'b1;
          w_consume  = FILL_W'(CNT_W);
          if (w_hdr == '0) begin
            w_hdr_zero = 1'b1;
          end else if (64'(w_hdr) > CAP) begin
            w_hdr_ovf = 1'b1;
            w_clear   = 1'b1;
          end else begin
            w_state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (r_fill >= FILL_W'(ELEM_W)) begin
          w_elem_take = 1'b1;
          w_consume   = FILL_W'(ELEM_W);
          if (r_k == K_W'(r_n) - K_W'(1)) begin
            w_last       = 1'b1;
            w_clear      = 1'b1;
            w_state_next = ST_HDR;
          end
        end
      end
      default: w_state_next = ST_HDR;
    endcase
  end

  // The final element's edge clears the buffer, so no word may land on it.
  assign w_final    = w_elem_take & w_last;
  assign w_in_ready = !rst && (r_fill <= FILL_W'(BUF_W - MAXB)) && !w_final;
  assign w_accept   = io_bus.in_valid && w_in_ready;

  // Buffer update: drop consumed bits (or everything on clear), then append.
  // An overflow clear only throws away what was already buffered; a word
  // accepted on that edge was handshaken and is kept.
  always_comb begin
    w_fill_keep = w_clear ? '0 : r_fill - w_consume;
    w_buf_keep  = w_clear ? '0 : r_buf << w_consume;
    w_buf_next  = w_buf_keep;
    w_fill_next = w_fill_keep;
    if (w_accept) begin
      w_buf_next  = w_buf_keep | (w_exp_top >> w_fill_keep);
      w_fill_next = w_fill_keep + FILL_W'(w_add);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_HDR;
      r_fill    <= '0;
      // NOTE: the buffer storage is reset too, not just r_fill, because
      // appends OR into it and rely on everything past the fill being zero.
      r_buf     <= '0;
      r_k       <= '0;
      r_n       <= '0;
      r_wr_en   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_fill    <= w_fill_next;
      r_buf     <= w_buf_next;
      r_wr_en   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      if (w_hdr_take) begin
        r_err  <= w_hdr_ovf;
        r_done <= w_hdr_zero | w_hdr_ovf;
        r_n    <= w_hdr;
        r_k    <= '0;
      end
      if (w_elem_take) begin
        r_wr_en   <= NBANK'(1) << (r_k % K_W'(NBANK));
        r_wr_addr <= ADDR_W'(r_k / K_W'(NBANK));
        r_wr_data <= w_ext;
        r_k       <= r_k + K_W'(1);
        r_done    <= w_last;
      end
    end
  end

  assign io_bus.in_ready = w_in_ready;
  assign io_bus.wr_en    = r_wr_en;
  assign io_bus.wr_addr  = r_wr_addr;
  assign io_bus.wr_data  = r_wr_data;
  assign o_busy          = (r_state == ST_DATA);
  assign o_done          = r_done;
  assign o_err           = r_err;

endmodule

// File: tb/tb_rle_bank_loader.sv
// -----------------------------------------------------------------------------
// tb_rle_bank_loader
// Directed frames for rle_bank_loader against a bit-queue model of the frame
// format; a negedge compare process checks every output every cycle, and each
// scenario also pins a few hand-computed literal results.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rle_bank_loader;

  localparam int WORD_W = 32;
  localparam int RUN_W  = 3;
  localparam int CNT_W  = 16;
  localparam int ELEM_W = 16;
  localparam int OUT_W  = 64;
  localparam int NBANK  = 4;
  localparam int ADDR_W = 10;
  localparam int BUF_W  = 128;
  localparam int NGRP   = WORD_W / (RUN_W + 1);
  localparam int RMAX   = (1 << RUN_W) - 1;
  localparam int MAXB   = NGRP * RMAX;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o_busy, o_done, o_err;

  rle_bank_loader_if #(.WORD_W(WORD_W), .NBANK(NBANK), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();

  rle_bank_loader #(
    .WORD_W(WORD_W), .RUN_W(RUN_W), .CNT_W(CNT_W), .ELEM_W(ELEM_W),
    .OUT_W(OUT_W), .NBANK(NBANK), .ADDR_W(ADDR_W), .BUF_W(BUF_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave),
    .o_busy (o_busy),
    .o_done (o_done),
    .o_err  (o_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ext(input logic [15:0] e);
`ifdef RLE_BANK_LOADER_SIGN_EXT_EN
    return {{48{e[15]}}, e};
`else
    return {48'h0, e};
`endif
  endfunction

  // ---------------- model: frame format over a queue of bits ----------------
  bit               mq[$];
  bit               m_in_frame = 0;
  int               mk = 0;
  int               mn = 0;
  logic [NBANK-1:0] m_wr_en = '0;
  logic [9:0]       m_addr = '0;
  logic [63:0]      m_wdata = '0;
  logic             m_done = 0;
  logic             m_err = 0;

  function automatic bit m_final();
    return m_in_frame && (mq.size() >= ELEM_W) && (mk == mn - 1);
  endfunction

  function automatic bit m_ready();
    return !rst && ((BUF_W - mq.size()) >= MAXB) && !m_final();
  endfunction

  function automatic logic [15:0] pop_field(input int w);
    logic [15:0] v = '0;
    for (int i = 0; i < w; i++) v = {v[14:0], mq.pop_front()};
    return v;
  endfunction

  task automatic model_step();
    bit acc, clr;
    int fill0;
    logic [15:0] f;
    logic [3:0] grp;
    acc = bus.in_valid && m_ready();
    if (rst) begin
      mq.delete();
      m_in_frame = 0; mk = 0; mn = 0;
      m_wr_en = '0; m_addr = '0; m_wdata = '0; m_done = 0; m_err = 0;
    end else begin
      m_wr_en = '0; m_addr = '0; m_wdata = '0; m_done = 0; clr = 0;
      fill0 = mq.size();
      if (!m_in_frame) begin
        if (fill0 >= CNT_W) begin
          f = pop_field(CNT_W);
          m_err = 0;
          if (f == 0) m_done = 1;
          else if (int'(f) > (NBANK << ADDR_W)) begin m_err = 1; m_done = 1; clr = 1; end
          else begin mn = int'(f); mk = 0; m_in_frame = 1; end
        end
      end else if (fill0 >= ELEM_W) begin
        f = pop_field(ELEM_W);
        m_wr_en = NBANK'(1 << (mk % NBANK));
        m_addr  = 10'(mk / NBANK);
        m_wdata = ext(f);
        mk++;
        if (mk == mn) begin m_done = 1; clr = 1; m_in_frame = 0; end
      end
      if (clr) mq.delete();
      if (acc) begin
        for (int g = 0; g < NGRP; g++) begin
          grp = bus.in_data[WORD_W-1-4*g -: 4];
          for (int r = 0; r < int'(grp[2:0]); r++) mq.push_back(grp[3]);
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  // ---------------- compare process + observation log ----------------
  typedef struct {
    logic [NBANK-1:0] en;
    logic [9:0]       addr;
    logic [63:0]      data;
    logic             done;
  } wr_t;

  wr_t wlog[$];
  int  done_cnt = 0;
  bit  err_seen = 0;
  bit  stall_seen = 0;
  bit  chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", bus.in_ready, m_ready());
      check("wr_en",    bus.wr_en,    m_wr_en);
      check("wr_addr",  bus.wr_addr,  m_addr);
      check("wr_data",  bus.wr_data,  m_wdata);
      check("done",     o_done,       m_done);
      check("busy",     o_busy,       m_in_frame);
      check("err",      o_err,        m_err);
      if (bus.wr_en != '0) wlog.push_back('{bus.wr_en, bus.wr_addr, bus.wr_data, o_done});
      if (o_done) done_cnt++;
      if (o_err) err_seen = 1;
      if (!rst && bus.in_valid && !bus.in_ready) stall_seen = 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  bit               bq[$];
  logic [15:0]      eq[$];
  logic [WORD_W-1:0] wq[$];
  bit               abort = 0;

  task automatic push_field(input int v, input int w);
    for (int b = w - 1; b >= 0; b--) bq.push_back(v[b]);
  endtask

  // Greedy RLE encoding of bq into words appended to wq; the last word is
  // padded with zero-count groups.
  task automatic encode();
    int i, r;
    bit v;
    logic [WORD_W-1:0] w;
    i = 0;
    while (i < bq.size()) begin
      w = '0;
      for (int g = 0; g < NGRP; g++) begin
        r = 0; v = 0;
        if (i < bq.size()) begin
          v = bq[i];
          while (r < RMAX && i < bq.size() && bq[i] == v) begin r++; i++; end
        end
        w = {w[WORD_W-5:0], v, 3'(r)};
      end
      wq.push_back(w);
    end
  endtask

  task automatic build_frame(input int n);
    bq.delete();
    push_field(n, CNT_W);
    foreach (eq[i]) push_field(int'(eq[i]), ELEM_W);
    encode();
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    bit ok = 0;
    int tries = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!ok && !abort) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      tries++;
      if (!ok && tries >= 300) begin
        n_checks++; n_errors++;
        $display("FAIL handshake_timeout: word 0x%0h not accepted in %0d cycles", w, tries);
        abort = 1;
      end
    end
  endtask

  task automatic send_all();
    for (int i = 0; i < wq.size(); i++) begin
      if (!abort) send_word(wq[i]);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic clear_logs();
    wlog.delete();
    done_cnt = 0; err_seen = 0; stall_seen = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int bad;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state
    @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Frame N=2: 0x8001, 0x0003
    clear_logs(); wq.delete();
    eq = '{16'h8001, 16'h0003};
    build_frame(2);
    send_all();
    idle(30);
    check("t1_nwrites", wlog.size(), 2);
    if (wlog.size() >= 2) begin
      check("t1_w0_en", wlog[0].en, 4'b0001);
      check("t1_w0_addr", wlog[0].addr, 0);
`ifdef RLE_BANK_LOADER_SIGN_EXT_EN
      check("t1_w0_data", wlog[0].data, 64'hFFFF_FFFF_FFFF_8001);
`else
      check("t1_w0_data", wlog[0].data, 64'h0000_0000_0000_8001);
`endif
      check("t1_w0_done", wlog[0].done, 0);
      check("t1_w1_en", wlog[1].en, 4'b0010);
      check("t1_w1_addr", wlog[1].addr, 0);
      check("t1_w1_data", wlog[1].data, 64'h3);
      check("t1_w1_done", wlog[1].done, 1);
    end
    check("t1_done_cnt", done_cnt, 1);

    // N=0 header, then a normal N=1 frame
    clear_logs(); wq.delete();
    wq.push_back(32'h7720_0000);
    eq = '{16'h1234};
    build_frame(1);
    send_all();
    idle(30);
    check("t2_done_cnt", done_cnt, 2);
    check("t2_nwrites", wlog.size(), 1);
    if (wlog.size() >= 1) begin
      check("t2_w0_en", wlog[0].en, 4'b0001);
      check("t2_w0_data", wlog[0].data, 64'h1234);
    end
    check("t2_busy", o_busy, 0);

    // Overflow N=4097, then N=1 clears err
    clear_logs(); wq.delete();
    eq.delete();
    build_frame(4097);
    eq = '{16'h00A5};
    build_frame(1);
    send_all();
    idle(30);
    check("t3_err_seen", err_seen, 1);
    check("t3_err_end", o_err, 0);
    check("t3_done_cnt", done_cnt, 2);
    check("t3_nwrites", wlog.size(), 1);
    if (wlog.size() >= 1) check("t3_w0_data", wlog[0].data, 64'hA5);

    // N=9 round-robin
    clear_logs(); wq.delete();
    eq.delete();
    for (int i = 0; i < 9; i++) eq.push_back(16'h1000 + 16'(i));
    build_frame(9);
    send_all();
    idle(30);
    check("t4_nwrites", wlog.size(), 9);
    if (wlog.size() >= 9) begin
      logic [3:0] en_exp [9] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
      int         ad_exp [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
      for (int i = 0; i < 9; i++) begin
        check($sformatf("t4_en%0d", i), wlog[i].en, en_exp[i]);
        check($sformatf("t4_addr%0d", i), wlog[i].addr, ad_exp[i]);
      end
      check("t4_data8", wlog[8].data, 64'h1008);
    end

    // Stall: header N=20 then all-ones words
    clear_logs(); wq.delete();
    eq.delete();
    build_frame(20);
    repeat (6) wq.push_back(32'hFFFF_FFFF);
    send_all();
    idle(30);
    check("t5_stall_seen", stall_seen, 1);
    check("t5_nwrites", wlog.size(), 20);
    bad = 0;
    foreach (wlog[i]) if (wlog[i].data !== ext(16'hFFFF)) bad++;
    check("t5_data_bad", bad, 0);
    check("t5_done_cnt", done_cnt, 1);
    if (wlog.size() >= 20) begin
      check("t5_last_en", wlog[19].en, 4'b1000);
      check("t5_last_addr", wlog[19].addr, 4);
    end

    // Reset after 3 of 5 writes
    clear_logs(); wq.delete();
    eq = '{16'h0F0F, 16'h1111, 16'h2222, 16'h3333, 16'h4444};
    build_frame(5);
    abort = 0;
    fork
      send_all();
      begin
        int c = 0;
        while (wlog.size() < 3 && c < 400) begin
          @(negedge clk); #1;
          c++;
        end
        if (wlog.size() < 3) begin
          n_checks++; n_errors++;
          $display("FAIL t6_wait_writes: saw %0d writes, expected 3 within bound", wlog.size());
        end
        rst = 1'b1;
        abort = 1;
      end
    join
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("t6_rst_wr_en", bus.wr_en, 0);
    check("t6_rst_wr_addr", bus.wr_addr, 0);
    check("t6_rst_wr_data", bus.wr_data, 0);
    check("t6_rst_done", o_done, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    abort = 0;
    idle(10);
    check("t6_nwrites", wlog.size(), 3);

    // Fresh frame after reset starts at bank 0, address 0
    clear_logs(); wq.delete();
    eq = '{16'h0ABC, 16'h0DEF};
    build_frame(2);
    send_all();
    idle(30);
    check("t7_nwrites", wlog.size(), 2);
    if (wlog.size() >= 1) begin
      check("t7_w0_en", wlog[0].en, 4'b0001);
      check("t7_w0_addr", wlog[0].addr, 0);
      check("t7_w0_data", wlog[0].data, 64'hABC);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
